// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller and the
// consumers of its flush/bubble controls.
package pipe_pkg;

    // Mult/div occupancy FSM states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Architectural zero register: writes are discarded, so it never carries a dependency
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // Instruction word loaded by IF/ID on flush and by ID/EX on bubble
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Width of the mult/div occupancy down-counter (covers MD_CYCLES up to 255)
    localparam int          MD_CNT_W = 8;

endpackage : pipe_pkg

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: IDLE/BUSY FSM with a down-counter.
// A start pulse in cycle c holds busy high for cycles c+1 .. c+MD_CYCLES.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    md_state_t             r_state;
    logic [MD_CNT_W-1:0]   r_cnt;

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_CYCLES - 1);

    // FSM and counter: load on start, count down while BUSY, return to IDLE when the count reaches 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= BUSY;
                        r_cnt   <= LOAD_VAL;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state == BUSY);

endmodule : md_busy_timer

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline. Owns the PC and
// IF/ID write enables, the IF/ID flush and the ID/EX bubble insert, and
// launches/tracks the multi-cycle mult/div unit.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             id_muldiv,
    input  logic             id_hilo,
    input  logic             br_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             w_lu;
    logic             w_md_hz;
    logic             w_stall;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .busy  (w_md_busy)
    );

    // Hazard detection and stall/flush/bubble steering; stall takes priority over a taken branch
    always_comb begin
        w_lu = ex_memread && (ex_rd != REG_ZERO) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        w_md_hz = w_md_busy && (id_muldiv || id_hilo);
        w_stall = w_lu || w_md_hz;

        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;

        if (w_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = br_taken;
            md_start   = id_muldiv;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance with MD_CYCLES=4, a second
// instance with MD_CYCLES=1 on the same inputs, both with an 8-bit stall counter.
module tb_pipe_hazard_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_use_rs, id_use_rt, ex_memread, id_muldiv, id_hilo, br_taken;

    logic          pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy;
    logic [CW-1:0] stall_cnt;
    logic          pc_we1, ifid_we1, ifid_flush1, idex_bubble1, md_start1, md_busy1;
    logic [CW-1:0] stall_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .id_muldiv(id_muldiv), .id_hilo(id_hilo),
        .br_taken(br_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MD_CYCLES(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .id_muldiv(id_muldiv), .id_hilo(id_hilo),
        .br_taken(br_taken),
        .pc_we(pc_we1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1),
        .md_start(md_start1), .md_busy(md_busy1), .stall_cnt(stall_cnt1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare the five combinational controls against {pc_we, ifid_we, flush, bubble, md_start}
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check_val(tag, {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, md_start}, {27'd0, exp});
    endtask

    task automatic clr_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
        id_muldiv = 1'b0; id_hilo = 1'b0; br_taken = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Control patterns {pc_we, ifid_we, flush, bubble, md_start}
    localparam logic [4:0] RUN   = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11100;
    localparam logic [4:0] START = 5'b11001;

    initial begin
        rst = 1'b1;
        clr_inputs();
        #1;
        check_val("rst_busy", {31'd0, md_busy}, 32'd0);
        check_val("rst_cnt", {24'd0, stall_cnt}, 32'd0);
        check_ctl("rst_ctl", RUN);
        step();
        rst = 1'b0;
        step();

        // Load-use on rs: lw $t0 in EX, add reading $t0 in ID
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1 check_ctl("lu_rs_stall", STALL);
        step();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1 check_ctl("lu_rs_release", RUN);
        check_val("lu_rs_cnt", {24'd0, stall_cnt}, 32'd1);

        // rt matches but the instruction does not read rt -> no stall; then it does
        clr_inputs();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b0;
        #1 check_ctl("lu_rt_unused", RUN);
        id_use_rt = 1'b1;
        #1 check_ctl("lu_rt_stall", STALL);
        step();
        clr_inputs();
        #1 check_val("lu_rt_cnt", {24'd0, stall_cnt}, 32'd2);

        // Register 0 never stalls; non-load producer never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1 check_ctl("lu_r0", RUN);
        ex_memread = 1'b0; ex_rd = 5'd5; id_rs = 5'd5;
        #1 check_ctl("no_load", RUN);
        step();
        check_val("noload_cnt", {24'd0, stall_cnt}, 32'd2);

        // Taken branch without hazard
        clr_inputs();
        br_taken = 1'b1;
        #1 check_ctl("br_flush", FLUSH);
        // Taken branch with concurrent load-use: stall wins
        ex_memread = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
        #1 check_ctl("br_lu_stall", STALL);
        step();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1 check_ctl("br_after", FLUSH);
        check_val("br_cnt", {24'd0, stall_cnt}, 32'd3);
        clr_inputs();

        // mult in cycle 0, mfhi from cycle 1
        id_muldiv = 1'b1;
        #1 check_ctl("md_start", START);
        check_val("md_idle", {31'd0, md_busy}, 32'd0);
        step();
        id_muldiv = 1'b0; id_hilo = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check_val($sformatf("md_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
            check_ctl($sformatf("md_stall_c%0d", c), STALL);
            if (c == 1) check_val("md1_busy_c1", {31'd0, md_busy1}, 32'd1);
            if (c == 2) check_val("md1_free_c2", {30'd0, md_busy1, pc_we1}, 32'd1);
            step();
        end
        check_val("md_busy_c5", {31'd0, md_busy}, 32'd0);
        check_ctl("md_proceed_c5", RUN);
        check_val("md_cnt", {24'd0, stall_cnt}, 32'd7);
        check_val("md1_cnt", {24'd0, stall_cnt1}, 32'd4);

        // A second mult while BUSY is held off and does not pulse md_start
        clr_inputs();
        id_muldiv = 1'b1;
        step();
        #1 check_ctl("md_busy_restart", STALL);

        // Reset in cycle 2 of BUSY with mfhi pending
        id_muldiv = 1'b0; id_hilo = 1'b1;
        step();
        check_val("md_busy_c2", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        check_val("rst_mid_cnt", {24'd0, stall_cnt}, 32'd0);
        check_ctl("rst_mid_ctl", RUN);
        step();
        rst = 1'b0;
        step();
        check_val("post_rst_busy", {31'd0, md_busy}, 32'd0);
        check_ctl("post_rst_ctl", RUN);
        check_val("post_rst_cnt", {24'd0, stall_cnt}, 32'd0);

        // Saturation: 2^CW + 3 stalled cycles
        clr_inputs();
        ex_memread = 1'b1; ex_rd = 5'd17; id_rs = 5'd17; id_use_rs = 1'b1;
        for (int i = 0; i < (1 << CW) - 2; i++) step();
        check_val("sat_pre", {24'd0, stall_cnt}, 32'd254);
        for (int i = 0; i < 5; i++) step();
        check_val("sat_hold", {24'd0, stall_cnt}, 32'd255);
        check_val("sat_hold1", {24'd0, stall_cnt1}, 32'd255);
        clr_inputs();
        step();
        check_val("sat_idle", {24'd0, stall_cnt}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Watches the instruction in ID, the instruction in EX, branch resolution and the multi-cycle multiply/divide unit. Drives the write enables of the PC and the IF/ID register, the IF/ID flush, and the ID/EX bubble insert. Sits beside the IF/ID and ID/EX pipeline registers; the only owner of their stall/flush controls.

## Interface
- MD_CYCLES, 32, mult/div occupancy in cycles, legal range 1..255
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  5 each  source register numbers of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- ex_rd  in  5  destination register of the EX instruction
- ex_memread  in  1  EX instruction is a load
- id_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- br_taken  in  1  branch/jump in ID resolved taken this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable (0 = hold, i.e. stall)
- ifid_flush  out  1  IF/ID loads all-zero (nop) at next edge
- idex_bubble  out  1  ID/EX loads nop at next edge
- md_start  out  1  one-cycle pulse, launches mult/div unit
- md_busy  out  1  registered, mult/div unit occupied
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Load-use hazard (combinational): lu = ex_memread & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- Mult/div hazard: md_hz = md_busy & (id_muldiv | id_hilo).
- stall = lu | md_hz. When stall: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, md_start=0.
- No stall: pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=br_taken, md_start=id_muldiv.
- Priority: stall beats flush; a taken branch during a stall is ignored and re-evaluated next cycle with the same ID instruction.
- FSM states IDLE, BUSY. IDLE -> BUSY on md_start, loading counter with MD_CYCLES-1. BUSY: counter decrements each cycle; BUSY -> IDLE on the edge where the counter is 0. md_busy = (state == BUSY).
- A new mult/div cannot start while BUSY; it is stalled by md_hz, so md_start never asserts in BUSY.
- stall_cnt increments on every edge where stall=1; saturates at all-ones, no wrap.
- Register 0 never causes a load-use stall.

## Timing
- All outputs except md_busy and stall_cnt are combinational from current-cycle inputs and state; zero-cycle latency.
- Load-use: exactly one stall cycle per hazard (the load leaves EX at the next edge).
- md_start in cycle c -> md_busy=1 in cycles c+1..c+MD_CYCLES; dependent mfhi in ID is stalled through cycle c+MD_CYCLES and proceeds in c+MD_CYCLES+1.
- MD_CYCLES=1: BUSY lasts exactly one cycle.
- Reset (any time, including mid-BUSY): state IDLE, counter 0, md_busy=0, stall_cnt=0 immediately; combinational outputs then follow inputs (with no hazard inputs: pc_we=1, ifid_we=1, flush=0, bubble=0, md_start=0).
- Release of rst synchronous to clk assumed by the system; block tolerates release on any edge.

## Structure
- Shared package pipe_pkg: state enum (IDLE, BUSY), REG_ZERO constant, NOP encoding (32'h0) used by flush/bubble consumers.
- One sub-module natural: md_busy_timer (counter + IDLE/BUSY FSM, inputs start, outputs busy). Hazard equations and stall counter stay in the top.

## Test plan
- lw $t0 in EX, add using $t0 (rs) in ID -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle all released; stall_cnt=1.
- lw with ex_rd=0, ID reads $0 -> no stall.
- Taken branch, no hazard -> ifid_flush=1, pc_we=1 for that cycle only; same with concurrent load-use -> flush=0, stall=1, flush asserted next cycle.
- MD_CYCLES=4: mult in cycle 0 (md_start=1), mfhi in ID cycle 1 -> stalled cycles 1-4, proceeds cycle 5; stall_cnt=4.
- rst pulse in cycle 2 of BUSY -> md_busy=0 at once, pending mfhi proceeds without stall.
- Force 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones.
